// File: rtl/alu_issue_pkg.sv
// Shared encodings and bench-facing request type for the ALU issue arbiter.
package alu_issue_pkg;

    localparam logic [2:0] ADD  = 3'b000;
    localparam logic [2:0] SL   = 3'b001;
    localparam logic [2:0] SLT  = 3'b010;
    localparam logic [2:0] SLTU = 3'b011;
    localparam logic [2:0] XOR  = 3'b100;
    localparam logic [2:0] SR   = 3'b101;
    localparam logic [2:0] OR   = 3'b110;
    localparam logic [2:0] AND  = 3'b111;

    localparam int unsigned F7_ALT_BIT = 5;

    typedef struct packed {
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] op1;
        logic [31:0] op2;
    } alu_req_t;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; funct7 alternate bit selects SUB / SRA.
module alu
    import alu_issue_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] operand_1,
    input  logic [XLEN-1:0] operand_2,
    output logic [XLEN-1:0] result
);

    localparam int unsigned SHAMT_W = (XLEN == 64) ? 6 : 5;

    logic [SHAMT_W-1:0] shamt;
    logic               alt;
    logic               unused_funct7;

    assign shamt         = operand_2[SHAMT_W-1:0];
    assign alt           = funct7[F7_ALT_BIT];
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        result = '0;
        unique case (funct3)
            ADD:  result = alt ? (operand_1 - operand_2) : (operand_1 + operand_2);
            SL:   result = operand_1 << shamt;
            SLT:  result = {{(XLEN-1){1'b0}}, $signed(operand_1) < $signed(operand_2)};
            SLTU: result = {{(XLEN-1){1'b0}}, operand_1 < operand_2};
            XOR:  result = operand_1 ^ operand_2;
            SR:   result = alt ? XLEN'($signed(operand_1) >>> shamt) : (operand_1 >> shamt);
            OR:   result = operand_1 | operand_2;
            AND:  result = operand_1 & operand_2;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping at N-1.
module rr_arbiter #(
    parameter  int unsigned N     = 2,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    // Pick the requester with the smallest circular distance from ptr.
    always_comb begin
        int unsigned ptr_u;
        int unsigned best_d;
        int unsigned d;
        ptr_u     = 32'(ptr);
        best_d    = N;
        d         = 0;
        grant     = '0;
        grant_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            d = (i >= ptr_u) ? (i - ptr_u) : (i + N - ptr_u);
            if (req[i] && (d < best_d)) begin
                best_d    = d;
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Round-robin share of one ALU across N_REQ requesters with a one-entry result register.
// Optional performance counters are enabled with ALU_ISSUE_ARB_PERF_EN.
module alu_issue_arbiter
    import alu_issue_pkg::*;
#(
    parameter  int unsigned XLEN  = 32,
    parameter  int unsigned N_REQ = 2,
    localparam int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*3-1:0]    req_funct3,
    input  logic [N_REQ*7-1:0]    req_funct7,
    input  logic [N_REQ*XLEN-1:0] req_op1,
    input  logic [N_REQ*XLEN-1:0] req_op2,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
`ifdef ALU_ISSUE_ARB_PERF_EN
    output logic [XLEN-1:0]       resp_result,
    output logic [N_REQ*32-1:0]   perf_grant_cnt,
    output logic [31:0]           perf_stall_cnt
`else
    output logic [XLEN-1:0]       resp_result
`endif
);

    logic [ID_W-1:0]  rr_ptr_q;
    logic             resp_valid_q;
    logic [ID_W-1:0]  resp_id_q;
    logic [XLEN-1:0]  resp_result_q;

    logic             can_issue;
    logic             xfer;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_idx;

    logic [2:0]       sel_funct3;
    logic [6:0]       sel_funct7;
    logic [XLEN-1:0]  sel_op1;
    logic [XLEN-1:0]  sel_op2;
    logic [XLEN-1:0]  alu_result;

    assign can_issue = ~resp_valid_q | resp_ready;
    assign req_ready = grant & {N_REQ{can_issue}};
    assign xfer      = |req_ready;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // One-hot AND-OR mux; operands stay zero when nothing is granted.
    always_comb begin
        sel_funct3 = '0;
        sel_funct7 = '0;
        sel_op1    = '0;
        sel_op2    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_funct3 = sel_funct3 | req_funct3[i*3 +: 3];
                sel_funct7 = sel_funct7 | req_funct7[i*7 +: 7];
                sel_op1    = sel_op1 | req_op1[i*XLEN +: XLEN];
                sel_op2    = sel_op2 | req_op2[i*XLEN +: XLEN];
            end
        end
    end

    alu #(
        .XLEN (XLEN)
    ) u_alu (
        .funct3    (sel_funct3),
        .funct7    (sel_funct7),
        .operand_1 (sel_op1),
        .operand_2 (sel_op2),
        .result    (alu_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q      <= '0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_result_q <= '0;
        end else if (xfer) begin
            resp_valid_q  <= 1'b1;
            resp_id_q     <= grant_idx;
            resp_result_q <= alu_result;
            rr_ptr_q      <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if (resp_ready) begin
            resp_valid_q  <= 1'b0;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;

`ifdef ALU_ISSUE_ARB_PERF_EN
    logic [N_REQ-1:0][31:0] grant_cnt_q;
    logic [31:0]            stall_cnt_q;
    logic                   stall;

    assign stall = (|req_valid) & ~can_issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (req_ready[i] && req_valid[i] && (grant_cnt_q[i] != '1)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
                end
            end
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_grant_cnt = grant_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Scoreboard bench for alu_issue_arbiter (N_REQ=3, XLEN=32) with a queue-based reference model.
module tb_alu_issue_arbiter;
    import alu_issue_pkg::*;

    localparam int N    = 3;
    localparam int XLEN = 32;
    localparam int ID_W = $clog2(N);

    logic                clk;
    logic                rst_n;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N*3-1:0]      req_funct3;
    logic [N*7-1:0]      req_funct7;
    logic [N*XLEN-1:0]   req_op1;
    logic [N*XLEN-1:0]   req_op2;
    logic                resp_valid;
    logic                resp_ready;
    logic [ID_W-1:0]     resp_id;
    logic [XLEN-1:0]     resp_result;
`ifdef ALU_ISSUE_ARB_PERF_EN
    logic [N*32-1:0]     perf_grant_cnt;
    logic [31:0]         perf_stall_cnt;
`endif

    alu_issue_arbiter #(
        .XLEN  (XLEN),
        .N_REQ (N)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_funct3     (req_funct3),
        .req_funct7     (req_funct7),
        .req_op1        (req_op1),
        .req_op2        (req_op2),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_id        (resp_id),
`ifdef ALU_ISSUE_ARB_PERF_EN
        .resp_result    (resp_result),
        .perf_grant_cnt (perf_grant_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`else
        .resp_result    (resp_result)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] res;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    alu_req_t    pend_req[N];
    logic [N-1:0] pend_valid;
    logic        drv_ready;

    int          m_ptr;
    logic        m_valid;
    int          m_id;
    logic [31:0] m_res;
    int          m_gcnt[N];
    int          m_stall;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input alu_req_t r);
        int sh;
        sh = int'(r.op2 % 32);
        case (r.funct3)
            3'd0: return r.funct7[5] ? r.op1 - r.op2 : r.op1 + r.op2;
            3'd1: return r.op1 << sh;
            3'd2: return ($signed(r.op1) < $signed(r.op2)) ? 32'd1 : 32'd0;
            3'd3: return (r.op1 < r.op2) ? 32'd1 : 32'd0;
            3'd4: return r.op1 ^ r.op2;
            3'd5: return r.funct7[5] ? 32'($signed(r.op1) >>> sh) : r.op1 >> sh;
            3'd6: return r.op1 | r.op2;
            default: return r.op1 & r.op2;
        endcase
    endfunction

    // Circular search from ptr; -1 when nobody is asking.
    function automatic int ref_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 3))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic alu_req_t rand_req();
        alu_req_t r;
        r.funct3 = 3'($urandom_range(0, 7));
        r.funct7 = 7'($urandom_range(0, 127));
        r.op1    = rand_operand();
        r.op2    = rand_operand();
        return r;
    endfunction

    function automatic alu_req_t mk(input logic [2:0] f3, input logic [6:0] f7,
                                    input logic [31:0] a, input logic [31:0] b);
        alu_req_t r;
        r.funct3 = f3;
        r.funct7 = f7;
        r.op1    = a;
        r.op2    = b;
        return r;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_id    = 0;
        m_res   = '0;
        m_stall = 0;
        for (int i = 0; i < N; i++) m_gcnt[i] = 0;
        exp_q.delete();
    endtask

    task automatic apply();
        req_valid  = pend_valid;
        resp_ready = drv_ready;
        for (int i = 0; i < N; i++) begin
            req_funct3[3*i +: 3]       = pend_req[i].funct3;
            req_funct7[7*i +: 7]       = pend_req[i].funct7;
            req_op1[XLEN*i +: XLEN]    = pend_req[i].op1;
            req_op2[XLEN*i +: XLEN]    = pend_req[i].op2;
        end
    endtask

    // One clock cycle: drive, check state at the negedge, advance the model.
    task automatic step();
        int           g;
        logic         can;
        logic [N-1:0] exp_rdy;
        exp_t         e;
        apply();
        @(negedge clk);
        g       = ref_pick(pend_valid, m_ptr);
        can     = !m_valid || drv_ready;
        exp_rdy = '0;
        if (g >= 0 && can) exp_rdy[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("resp_valid", 64'(resp_valid), 64'(m_valid));
        check("resp_id", 64'(resp_id), 64'(m_id));
        check("resp_result", 64'(resp_result), 64'(m_res));
        if ((|pend_valid) && !can) m_stall++;
        if (g >= 0 && can) begin
            e.id  = g;
            e.res = ref_alu(pend_req[g]);
            exp_q.push_back(e);
            m_valid       = 1'b1;
            m_id          = g;
            m_res         = e.res;
            m_ptr         = (g + 1) % N;
            m_gcnt[g]++;
            pend_valid[g] = 1'b0;
        end else if (drv_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drv_ready = 1'b1;
        for (int k = 0; k < N + 1; k++) step();
    endtask

    // Monitor: every handshake on the response side pops one expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got id %0d result %0h expected none",
                             resp_id, resp_result);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_id", 64'(resp_id), 64'(e.id));
                    check("sb_result", 64'(resp_result), 64'(e.res));
                end
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        pend_valid = '0;
        drv_ready  = 1'b1;
        for (int i = 0; i < N; i++) pend_req[i] = mk(3'd0, 7'd0, 32'd0, 32'd0);
        model_reset();
        apply();
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_id", 64'(resp_id), 64'd0);
        check("rst_resp_result", 64'(resp_result), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
        repeat (3) step();

        // ADD 5+7 from requester 0.
        pend_req[0] = mk(ADD, 7'h00, 32'd5, 32'd7);
        pend_valid[0] = 1'b1;
        step();
        step();

        // Two requesters contending every cycle.
        for (int k = 0; k < 6; k++) begin
            pend_req[0]   = mk(ADD, 7'h20, 32'd10, 32'd3);
            pend_req[1]   = mk(SLT, 7'h00, 32'hFFFF_FFFF, 32'd1);
            pend_valid[0] = 1'b1;
            pend_valid[1] = 1'b1;
            step();
        end
        drain();

        // Backpressure with an SRA result held.
        pend_req[0]   = mk(SR, 7'h20, 32'h8000_0000, 32'd27);
        pend_valid[0] = 1'b1;
        step();
        pend_req[1]   = mk(XOR, 7'h00, 32'h0F0F_0F0F, 32'hFFFF_0000);
        pend_req[2]   = mk(OR, 7'h00, 32'h0000_00F0, 32'h0000_000F);
        pend_valid[1] = 1'b1;
        pend_valid[2] = 1'b1;
        drv_ready     = 1'b0;
        repeat (3) step();
        drv_ready = 1'b1;
        step();
        drain();

        // Wrap-around: 2, then 0, then 2.
        pend_req[2]   = mk(AND, 7'h00, 32'h1234_5678, 32'h0000_FFFF);
        pend_valid[2] = 1'b1;
        step();
        pend_req[0]   = mk(SL, 7'h00, 32'd1, 32'd31);
        pend_req[2]   = mk(SLTU, 7'h00, 32'd3, 32'd4);
        pend_valid[0] = 1'b1;
        pend_valid[2] = 1'b1;
        step();
        step();
        drain();

        // Reset while a result is held and requester 1 is pending.
        drv_ready     = 1'b0;
        pend_req[0]   = mk(ADD, 7'h00, 32'h1230, 32'h4);
        pend_valid[0] = 1'b1;
        step();
        pend_req[1]   = mk(SLTU, 7'h00, 32'hFFFF_FFFF, 32'd1);
        pend_valid[1] = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(resp_valid), 64'd0);
        check("async_rst_result", 64'(resp_result), 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        drv_ready = 1'b1;
        step();
        step();

        // Randomized traffic; valid is held until accepted.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend_valid[i] && $urandom_range(0, 2) != 0) begin
                    pend_valid[i] = 1'b1;
                    pend_req[i]   = rand_req();
                end
            end
            drv_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();
        drain();
        check("sb_queue_empty", 64'(exp_q.size()), 64'd0);

`ifdef ALU_ISSUE_ARB_PERF_EN
        for (int i = 0; i < N; i++) begin
            check("perf_grant_cnt", 64'(perf_grant_cnt[32*i +: 32]), 64'(m_gcnt[i]));
        end
        check("perf_stall_cnt", 64'(perf_stall_cnt), 64'(m_stall));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Shares one combinational integer ALU (the core `alu` module, instantiated inside) between N_REQ requesters, for example the integer pipe and the address-generation / branch-compare path.
- Each cycle a round-robin arbiter picks one valid requester and drives its funct3/funct7/operands into the ALU.
- The result is captured in a one-entry output register with a valid/ready handshake and returned with the requester ID.

Parameters:
- XLEN, 32, operand/result width; only 32 or 64 are legal.
- N_REQ, 2, number of requesters; legal range 2..8.
- ID_W, $clog2(N_REQ), width of the response ID (derived localparam, not overridable).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; a transfer occurs when valid&ready.
- req_funct3  in  N_REQ*3  packed funct3; requester i occupies [3i+2:3i].
- req_funct7  in  N_REQ*7  packed funct7; requester i occupies [7i+6:7i].
- req_op1  in  N_REQ*XLEN  packed operand_1.
- req_op2  in  N_REQ*XLEN  packed operand_2.
- resp_valid  out  1  output register holds a result.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  ID_W  index of the requester that produced the result.
- resp_result  out  XLEN  ALU result.

Behaviour:
- Reset (async assert, release synchronous to clk): resp_valid=0, resp_id=0, resp_result=0, rr_ptr=0. req_ready is all-zero whenever resp_valid=0 and req_valid=0.
- can_issue = ~resp_valid | resp_ready. This is combinational, so a full output register that drains in the same cycle still allows issue.
- Arbitration is combinational: grant = first i with req_valid[i]=1, searching from rr_ptr upward and wrapping at N_REQ-1 back to 0. At most one grant bit is set.
- req_ready[i] = grant[i] & can_issue.
  - req_ready must not depend on the granted requester's own req_valid being stable beyond the grant.
  - Requesters hold valid and operands stable until accepted; once asserted, valid is never dropped.
- On a transfer from requester g at edge t:
  - resp_result <= ALU(funct3_g, funct7_g, op1_g, op2_g).
  - resp_id <= g.
  - resp_valid <= 1.
  - rr_ptr <= (g+1) mod N_REQ.
  - Latency is 1 cycle, and throughput is 1 result per cycle while resp_ready=1.
- Response held, no new issue (resp_valid=1, resp_ready=0): req_ready is all 0, resp_* is held stable, and rr_ptr is unchanged.
- Response consumed, no new transfer (resp_ready=1, no transfer): resp_valid <= 0. resp_result and resp_id hold their last values.
- Simultaneous drain and issue: the output register is overwritten in the same edge with no bubble.
- No requests: rr_ptr is unchanged and no power toggling on the ALU operand muxes is required.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,N_REQ-1,0. Worst-case wait is N_REQ-1 transfers.
- Reset asserted mid-operation discards any held result. Requesters must re-present any request that was not accepted.
- ALU semantics are unchanged:
  - funct7[5] selects SUB for funct3=000 and SRA for funct3=101.
  - The shift amount is operand_2[4:0] when XLEN=32 and [5:0] when XLEN=64.

Optional Feature:
- ALU_ISSUE_ARB_PERF_EN
- Defined adds:
  - output perf_grant_cnt, N_REQ*32 packed: per-requester count of accepted transfers.
  - output perf_stall_cnt, 32: cycles with any req_valid=1 and can_issue=0.
  - All counters reset to 0 on rst_n, saturate at 32'hFFFF_FFFF, and update on the same edge as the event.
- Undefined: these ports and counters do not exist, and the remaining behaviour is identical.

Decomposition:
- Package alu_issue_pkg holds:
  - localparams for the funct3 encodings: ADD=000, SL=001, SLT=010, SLTU=011, XOR=100, SR=101, OR=110, AND=111.
  - F7_ALT_BIT=5.
  - typedef alu_req_t, a struct of funct3, funct7, op1 and op2 at XLEN=32, for benches.
- Sub-module rr_arbiter is natural.
  - Parameter N.
  - Ports: req[N], ptr, grant[N] one-hot, grant_idx.
  - Purely combinational; it is reused later for the LSU port share.
- The ALU is instantiated once, unmodified.

Test Plan:
- Reset release with all req_valid=0: resp_valid=0 and req_ready=0 at every cycle; then req0 ADD 5+7 -> next cycle resp_valid=1, resp_result=12, resp_id=0.
- Both requesters valid every cycle, resp_ready=1, N_REQ=2: req0 SUB 10-3, req1 SLT -1<1 -> alternating results 7 (id0) and 1 (id1), one per cycle, starting with id0.
- Backpressure: resp_ready=0 for 3 cycles with result 0xFFFF_FFF0 (SRA of 0x8000_0000 by 27) held -> req_ready all 0, resp stable for 3 cycles; release -> next grant issues in the same cycle.
- Wrap-around with N_REQ=3: only req2 valid, then req0 and req2 valid -> grant order 2, 0, 2 (rr_ptr wraps 2->0).
- rst_n dropped while resp_valid=1 with result 0x1234 -> resp_valid=0 immediately (async); after release, pending req1 is re-granted and SLTU 0xFFFF_FFFF<1 yields 0.
- With ALU_ISSUE_ARB_PERF_EN: 4 grants to req0, 2 to req1, and 3 stall cycles -> perf_grant_cnt={2,4}, perf_stall_cnt=3.
